// File: rtl/pe_pipe.sv
// pe_pipe: two-stage pipelined vector lane processing element.
//
// Sits between operand fetch and writeback. Element width is selected per
// operation by vsew (8/16/32/64 bits, 64 only when W=64). Results occupy
// the low ew bits of out with the upper bits zero.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready depends only on state and out_ready)
//   a, b, c           vs2, vs1 (or shift amount), vd (MACC addend)
//   op                0 ADD 1 SUB 2 SLL 3 MUL 4 MACC 5 XOR 6 SRL 7 SRA
//                     8 OR 9 AND 10 MAX 11 MIN 12 ACC, 13-15 reserved (result 0)
//   vsew              element width select
//   is_signed, sat_en signedness and saturation controls
//   acc_clr           clear internal accumulator
//   out_valid/out_ready result handshake, out = result
//   sat_flag, sat_clr sticky saturation flag and its clear
//
// Optional feature: define PE_ACC_EN to build an internal accumulator for
// op ACC (result = acc + a*b). Without it ACC behaves like MACC using c.
module pe_pipe #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  input  logic [OPW-1:0] op,
  input  logic [1:0]     vsew,
  input  logic           is_signed,
  input  logic           sat_en,
  input  logic           acc_clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out,
  output logic           sat_flag,
  input  logic           sat_clr
);

  // Wide enough for a full product of two (W+2)-bit extended operands plus an addend.
  localparam int PW = 2*W + 4;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(2);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(3);
  localparam logic [OPW-1:0] OP_MACC = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
  localparam logic [OPW-1:0] OP_OR   = OPW'(8);
  localparam logic [OPW-1:0] OP_AND  = OPW'(9);
  localparam logic [OPW-1:0] OP_MAX  = OPW'(10);
  localparam logic [OPW-1:0] OP_MIN  = OPW'(11);
  localparam logic [OPW-1:0] OP_ACC  = OPW'(12);

  function automatic logic [6:0] ew_of(input logic [1:0] vs);
    case (vs)
      2'd0:    return 7'd8;
      2'd1:    return 7'd16;
      2'd2:    return 7'd32;
      default: return (W == 64) ? 7'd64 : 7'd32;
    endcase
  endfunction

  function automatic logic [W-1:0] ew_mask(input logic [6:0] ew);
    logic [W:0] one;
    logic [W:0] m;
    one = {{W{1'b0}}, 1'b1};
    m   = (one << ew) - one;
    return m[W-1:0];
  endfunction

  // Low ew bits of x, sign- or zero-extended to W+2 bits.
  function automatic logic signed [W+1:0] ext_fn(input logic [W-1:0] x,
                                                 input logic [6:0]   ew,
                                                 input logic         sgn);
    logic [W-1:0] m;
    logic [W-1:0] msb;
    logic [W+1:0] r;
    m   = ew_mask(ew);
    msb = m & ~(m >> 1);
    r   = {2'b00, x & m};
    if (sgn && |(x & msb))
      r = r | ~{2'b00, m};
    return signed'(r);
  endfunction

  // Clamp (when en) to the signed/unsigned ew range; returns {saturated, value}.
  function automatic logic [W:0] sat_fn(input logic signed [PW-1:0] v,
                                        input logic [6:0]          ew,
                                        input logic                sgn,
                                        input logic                en);
    logic signed [PW-1:0] one;
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    logic [W-1:0]         m;
    one = {{(PW-1){1'b0}}, 1'b1};
    m   = ew_mask(ew);
    if (sgn) begin
      hi = (one <<< (ew - 7'd1)) - one;
      lo = -(one <<< (ew - 7'd1));
    end else begin
      hi = (one <<< ew) - one;
      lo = '0;
    end
    if (en && (v > hi))
      return {1'b1, hi[W-1:0] & m};
    else if (en && (v < lo))
      return {1'b1, lo[W-1:0] & m};
    else
      return {1'b0, v[W-1:0] & m};
  endfunction

  logic                  w_s1_adv, w_s2_adv;
  logic [6:0]            w_ew;
  logic signed [W+1:0]   w_ea, w_eb, w_ec;
  logic signed [PW-1:0]  w_ea_x, w_eb_x, w_prod;

  logic                  r_vld_p1;
  logic [OPW-1:0]        r_op_p1;
  logic [6:0]            r_ew_p1;
  logic                  r_sgn_p1, r_sat_p1;
  logic [W-1:0]          r_a_p1, r_b_p1;
  logic signed [W+1:0]   r_ea_p1, r_eb_p1, r_ec_p1;
  logic signed [PW-1:0]  r_prod_p1;

  logic                  r_vld_p2, r_satd_p2;
  logic [W-1:0]          r_res_p2;
  logic                  r_sat_flag;

  assign w_s2_adv  = !r_vld_p2 || out_ready;
  assign w_s1_adv  = !r_vld_p1 || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_vld_p2;
  assign out       = r_res_p2;
  assign sat_flag  = r_sat_flag;

  assign w_ew   = ew_of(vsew);
  assign w_ea   = ext_fn(a, w_ew, is_signed);
  assign w_eb   = ext_fn(b, w_ew, is_signed);
  assign w_ec   = ext_fn(c, w_ew, is_signed);
  assign w_ea_x = {{(PW-W-2){w_ea[W+1]}}, w_ea};
  assign w_eb_x = {{(PW-W-2){w_eb[W+1]}}, w_eb};
  assign w_prod = w_ea_x * w_eb_x;

  // ---- Stage 1: decoded op, masked/extended operands, full product ----
  always_ff @(posedge clk) begin
    if (rst)
      r_vld_p1 <= 1'b0;
    else if (w_s1_adv)
      r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_op_p1   <= op;
      r_ew_p1   <= w_ew;
      r_sgn_p1  <= is_signed;
      r_sat_p1  <= sat_en;
      r_a_p1    <= a & ew_mask(w_ew);
      r_b_p1    <= b & ew_mask(w_ew);
      r_ea_p1   <= w_ea;
      r_eb_p1   <= w_eb;
      r_ec_p1   <= w_ec;
      r_prod_p1 <= w_prod;
    end
  end

  logic [6:0]           w_sh;
  logic signed [W+1:0]  w_sa;
  logic [W-1:0]         w_sra;
  logic signed [PW-1:0] w_ea_p, w_eb_p, w_ec_p, w_acc_add;
  logic signed [PW-1:0] w_wide;
  logic                 w_arith;
  logic [W-1:0]         w_lres;
  logic [W:0]           w_satres;
  logic [W-1:0]         w_res;
  logic                 w_satd;

  assign w_sh   = {1'b0, r_b_p1[5:0]} & (r_ew_p1 - 7'd1);
  assign w_sa   = ext_fn(r_a_p1, r_ew_p1, 1'b1);
  assign w_sra  = W'(w_sa >>> w_sh);
  assign w_ea_p = {{(PW-W-2){r_ea_p1[W+1]}}, r_ea_p1};
  assign w_eb_p = {{(PW-W-2){r_eb_p1[W+1]}}, r_eb_p1};
  assign w_ec_p = {{(PW-W-2){r_ec_p1[W+1]}}, r_ec_p1};

`ifdef PE_ACC_EN
  logic [W-1:0]        r_acc;
  logic [OPW-1:0]      r_op_p2;
  logic [W-1:0]        w_acc_src;
  logic signed [W+1:0] w_eacc;

  // An ACC result leaving S2 this cycle has not reached r_acc yet; forward it
  // so back-to-back ACC ops chain without a stall. acc_clr wins over both.
  assign w_acc_src = acc_clr ? '0 :
                     (r_vld_p2 && out_ready && (r_op_p2 == OP_ACC)) ? r_res_p2 : r_acc;
  assign w_eacc    = ext_fn(w_acc_src, r_ew_p1, r_sgn_p1);
  assign w_acc_add = {{(PW-W-2){w_eacc[W+1]}}, w_eacc};

  always_ff @(posedge clk) begin
    if (rst)
      r_acc <= '0;
    else if (acc_clr)
      r_acc <= '0;
    else if (r_vld_p2 && out_ready && (r_op_p2 == OP_ACC))
      r_acc <= r_res_p2;
  end

  always_ff @(posedge clk) begin
    if (w_s2_adv && r_vld_p1)
      r_op_p2 <= r_op_p1;
  end
`else
  logic w_unused_acc_clr;
  assign w_unused_acc_clr = acc_clr;
  assign w_acc_add        = w_ec_p;
`endif

  always_comb begin
    w_wide  = '0;
    w_arith = 1'b0;
    w_lres  = '0;
    case (r_op_p1)
      OP_ADD:  begin w_wide = w_ea_p + w_eb_p;       w_arith = 1'b1; end
      OP_SUB:  begin w_wide = w_ea_p - w_eb_p;       w_arith = 1'b1; end
      OP_MUL:  begin w_wide = r_prod_p1;             w_arith = 1'b1; end
      OP_MACC: begin w_wide = r_prod_p1 + w_ec_p;    w_arith = 1'b1; end
      OP_ACC:  begin w_wide = r_prod_p1 + w_acc_add; w_arith = 1'b1; end
      OP_XOR:  w_lres = r_a_p1 ^ r_b_p1;
      OP_OR:   w_lres = r_a_p1 | r_b_p1;
      OP_AND:  w_lres = r_a_p1 & r_b_p1;
      OP_SLL:  w_lres = r_a_p1 << w_sh;
      OP_SRL:  w_lres = r_a_p1 >> w_sh;
      OP_SRA:  w_lres = w_sra;
      // Ties keep a.
      OP_MAX:  w_lres = (r_eb_p1 > r_ea_p1) ? r_b_p1 : r_a_p1;
      OP_MIN:  w_lres = (r_eb_p1 < r_ea_p1) ? r_b_p1 : r_a_p1;
      default: ;
    endcase
    w_satres = sat_fn(w_wide, r_ew_p1, r_sgn_p1, r_sat_p1 && w_arith);
    if (w_arith) begin
      w_res  = w_satres[W-1:0];
      w_satd = w_satres[W];
    end else begin
      w_res  = w_lres & ew_mask(r_ew_p1);
      w_satd = 1'b0;
    end
  end

  // ---- Stage 2: final result and its saturation marker ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_res_p2 <= '0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1)
        r_res_p2 <= w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s2_adv && r_vld_p1)
      r_satd_p2 <= w_satd;
  end

  // Set on delivery of a saturated result; set wins over sat_clr.
  always_ff @(posedge clk) begin
    if (rst)
      r_sat_flag <= 1'b0;
    else if (r_vld_p2 && out_ready && r_satd_p2)
      r_sat_flag <= 1'b1;
    else if (sat_clr)
      r_sat_flag <= 1'b0;
  end

endmodule

// File: tb/tb_pe_pipe.sv
module tb_pe_pipe;
  localparam int W   = 32;
  localparam int OPW = 4;
`ifdef PE_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready;
  logic           is_signed, sat_en, acc_clr, sat_flag, sat_clr;
  logic [W-1:0]   a, b, c, out;
  logic [OPW-1:0] op;
  logic [1:0]     vsew;

  pe_pipe #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .op(op), .vsew(vsew), .is_signed(is_signed),
    .sat_en(sat_en), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, c;
    logic [1:0]   vsew;
    logic         sgn, sat;
    int           cyc;
  } txn_t;

  txn_t         q[$];
  logic [W-1:0] outs[$];
  int           checks = 0, failures = 0, cyc = 0, ndel = 0;
  logic [W-1:0] m_acc = '0, last_out = '0, prev_out = '0;
  logic         m_flag = 1'b0;
  bit           last_acc = 0, prev_hold = 0, lat_mode = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [127:0] sv(input logic [127:0] u, input int ew, input bit s);
    if (s && (u >= (128'd1 << (ew - 1)))) return u - (128'd1 << ew);
    return u;
  endfunction

  // Mathematical reference: interpret operands as integers, compute exactly, then clamp/wrap.
  function automatic void model(input txn_t t, input logic [W-1:0] acc,
                                output logic [W-1:0] res, output logic satd);
    int ew, sh;
    bit arith;
    logic [127:0] ua, ub, m;
    logic signed [127:0] va, vb, vc, vacc, sa, v, hi, lo;
    ew = (t.vsew == 0) ? 8 : (t.vsew == 1) ? 16 : (t.vsew == 3 && W == 64) ? 64 : 32;
    m  = (128'd1 << ew) - 128'd1;
    ua = 128'(t.a) & m;
    ub = 128'(t.b) & m;
    va = sv(ua, ew, t.sgn);
    vb = sv(ub, ew, t.sgn);
    vc = sv(128'(t.c) & m, ew, t.sgn);
    vacc = sv(128'(acc) & m, ew, t.sgn);
    sh = int'(ub % 128'(ew));
    arith = 0; v = 0; res = '0; satd = 0;
    case (t.op)
      4'd0:  begin v = va + vb; arith = 1; end
      4'd1:  begin v = va - vb; arith = 1; end
      4'd3:  begin v = va * vb; arith = 1; end
      4'd4:  begin v = va * vb + vc; arith = 1; end
      4'd12: begin v = va * vb + (ACC_EN ? vacc : vc); arith = 1; end
      4'd2:  res = W'((ua << sh) & m);
      4'd5:  res = W'(ua ^ ub);
      4'd6:  res = W'(ua >> sh);
      4'd7:  begin sa = sv(ua, ew, 1'b1); res = W'((sa >>> sh) & m); end
      4'd8:  res = W'(ua | ub);
      4'd9:  res = W'(ua & ub);
      4'd10: res = W'((vb > va) ? ub : ua);
      4'd11: res = W'((vb < va) ? ub : ua);
      default: res = '0;
    endcase
    if (arith) begin
      hi = t.sgn ? (128'sd1 <<< (ew - 1)) - 128'sd1 : $signed(m);
      lo = t.sgn ? -(128'sd1 <<< (ew - 1)) : 128'sd0;
      if (t.sat && v > hi) begin v = hi; satd = 1; end
      else if (t.sat && v < lo) begin v = lo; satd = 1; end
      res = W'(v & m);
    end
  endfunction

  // One clock: sample handshakes mid-low-phase, score, advance, check sat_flag.
  task automatic cycle();
    txn_t t, tin;
    logic [W-1:0] e;
    logic s;
    bit acc_h, del_h, del_is_acc;
    #1;
    acc_h = !rst && in_valid && in_ready;
    del_h = !rst && out_valid && out_ready;
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_out", out, prev_out);
    end
    e = '0; s = 0; del_is_acc = 0;
    if (del_h) begin
      ndel++;
      last_out = out;
      outs.push_back(out);
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        t = q.pop_front();
        model(t, m_acc, e, s);
        del_is_acc = (t.op == 4'd12);
        chk($sformatf("out_op%0d", t.op), out, e);
        if (lat_mode) chk("latency", cyc - t.cyc, 2);
      end
    end
    if (acc_h) begin
      tin = '{op, a, b, c, vsew, is_signed, sat_en, cyc};
      q.push_back(tin);
    end
    last_acc  = acc_h;
    prev_hold = !rst && out_valid && !out_ready;
    prev_out  = out;
    @(posedge clk);
    if (rst) begin
      m_flag = 0; m_acc = '0; q.delete();
    end else begin
      if (del_h && s) m_flag = 1;
      else if (sat_clr) m_flag = 0;
      if (ACC_EN) begin
        if (acc_clr) m_acc = '0;
        else if (del_h && del_is_acc) m_acc = e;
      end
    end
    cyc++;
    @(negedge clk);
    chk("sat_flag", sat_flag, m_flag);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin cycle(); n++; end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic setin(input logic [3:0] o, input logic [W-1:0] xa, xb, xc,
                       input logic [1:0] vs, input logic sg, st);
    op = o; a = xa; b = xb; c = xc; vsew = vs; is_signed = sg; sat_en = st;
  endtask

  task automatic send(input logic [3:0] o, input logic [W-1:0] xa, xb, xc,
                      input logic [1:0] vs, input logic sg, st);
    int n = 0;
    setin(o, xa, xb, xc, vs, sg, st);
    in_valid = 1; out_ready = 1;
    do begin cycle(); n++; end while (!last_acc && n < 20);
    chk("send_accepted", last_acc, 1);
    in_valid = 0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, ndel0;
    logic [W-1:0] ma[4], mb[4];
    rst = 1; in_valid = 0; out_ready = 0; acc_clr = 0; sat_clr = 0;
    setin(4'd0, '0, '0, '0, 2'd0, 0, 0);
    cycle(); cycle();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_in_ready", in_ready, 1);

    lat_mode = 1;
    send(4'd0, 'h7F, 'h01, '0, 2'd0, 1, 1);
    chk("add_sat_out", last_out, 'h7F);
    chk("add_sat_flag", sat_flag, 1);
    sat_clr = 1; cycle(); sat_clr = 0;
    chk("sat_clr_alone", sat_flag, 0);

    send(4'd1, 3, 5, '0, 2'd2, 0, 1);
    chk("usub_sat_out", last_out, 0);
    chk("usub_sat_flag", sat_flag, 1);
    send(4'd1, 3, 5, '0, 2'd2, 0, 0);
    chk("usub_wrap_out", last_out, 32'hFFFF_FFFE);
    chk("usub_wrap_flag", sat_flag, 1);

    sat_clr = 1;
    send(4'd0, 'h7F, 'h01, '0, 2'd0, 1, 1);
    chk("set_wins_flag", sat_flag, 1);
    cycle(); sat_clr = 0;
    chk("clr_next_flag", sat_flag, 0);

    send(4'd10, 'hFFFF, 'h0001, '0, 2'd1, 1, 0);
    chk("smax_out", last_out, 'h0001);
    send(4'd10, 'hFFFF, 'h0001, '0, 2'd1, 0, 0);
    chk("umax_out", last_out, 'hFFFF);
    send(4'd7, 'h80, 3, '0, 2'd0, 0, 0);
    chk("sra8_out", last_out, 'hF0);
    send(4'd13, 'h1234, 'h5678, '0, 2'd2, 1, 1);
    chk("reserved_out", last_out, 0);
`ifndef PE_ACC_EN
    send(4'd12, 2, 3, 4, 2'd2, 0, 0);
    chk("acc_as_macc", last_out, 10);
`endif
    lat_mode = 0;

    // Stall: four MULs against a blocked output for three cycles.
    for (int k = 0; k < 4; k++) begin ma[k] = $urandom; mb[k] = $urandom; end
    out_ready = 0; idx = 0; ndel0 = ndel;
    for (int k = 0; k < 3; k++) begin
      setin(4'd3, ma[idx], mb[idx], '0, 2'd2, 0, 0); in_valid = 1;
      cycle();
      if (last_acc) idx++;
    end
    chk("stall_accepted", idx, 2);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1;
    for (int n = 0; n < 20 && idx < 4; n++) begin
      setin(4'd3, ma[idx], mb[idx], '0, 2'd2, 0, 0); in_valid = 1;
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 0;
    drain();
    chk("stall_delivered", ndel - ndel0, 4);

`ifdef PE_ACC_EN
    acc_clr = 1; cycle(); acc_clr = 0;
    outs.delete();
    setin(4'd12, 2, 3, '0, 2'd2, 0, 0); in_valid = 1; out_ready = 1;
    for (int k = 0; k < 3; k++) cycle();
    in_valid = 0;
    drain();
    chk("acc_count", outs.size(), 3);
    for (int k = 0; k < 3 && k < outs.size(); k++) chk($sformatf("acc_out%0d", k), outs[k], 6 * (k + 1));
`endif

    // Reset in mid-stream: nothing in flight may be delivered.
    setin(4'd12, 2, 3, 1, 2'd2, 0, 0); in_valid = 1; out_ready = 1;
    cycle(); cycle();
    rst = 1; out_ready = 0;
    cycle();
    rst = 0; in_valid = 0;
    chk("midrst_out_valid", out_valid, 0);
    ndel0 = ndel; out_ready = 1;
    for (int k = 0; k < 4; k++) cycle();
    chk("midrst_no_delivery", ndel - ndel0, 0);
    send(4'd12, 2, 3, '0, 2'd2, 0, 0);
    chk("midrst_acc_zero", last_out, 6);

    // Randomised traffic with random back-pressure.
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      sat_clr   = ($urandom % 8) == 0;
      a = $urandom;
      b = (($urandom % 4) == 0) ? a : $urandom;
      c = $urandom;
      op = OPW'($urandom % 16);
      vsew = 2'($urandom % 4);
      is_signed = $urandom % 2;
      sat_en = $urandom % 2;
      cycle();
    end
    in_valid = 0; out_ready = 1; sat_clr = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
